change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Return path of the vending-machine coin interface: the payment block accepts coins and computes a change value; this block turns that value back into physical coin-eject pulses.
- Uses a greedy denomination choice (100/25/10/5) against per-denomination tube stock counters.
- Talks to the payment block through a four-phase request/done handshake, matching the cancel handshake.
- Refill inputs return accepted coins into the tubes.

Parameters:
- INIT_DOLLAR, 4, dollar tube count at reset
- INIT_QUARTER, 8, quarter tube count at reset
- INIT_DIME, 8, dime tube count at reset
- INIT_NICKEL, 8, nickel tube count at reset
- TUBE_MAX, 255, saturation limit per tube; must fit 8 bits
- GAP, 2, low cycles after each coin pulse, range 0..15
- LOW_THRESH, 2, changeLow asserts when nickel count < LOW_THRESH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- dispenseReq  input  1  change request, held high until dispenseDone is seen
- changeAmount  input  9  change value in cents, sampled when the request is accepted
- dollarIn, quarterIn, dimeIn, nickelIn  input  1 each  single-cycle coin-accepted pulses that refill the tubes
- dollarOut, quarterOut, dimeOut, nickelOut  output  1 each  single-cycle eject pulses
- dispenseDone  output  1  handshake acknowledge
- busy  output  1  high in every state except IDLE
- shortfall  output  9  cents that could not be paid for the last request
- changeLow  output  1  low-nickel warning

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - All coin outputs, dispenseDone, busy and shortfall are 0.
  - Tube counts load the INIT_* values.
  - A reset in the middle of a dispense abandons it; no further pulses, no done.
- Registers:
  - remaining: 9 bits.
  - Four tube counters: 8 bits each.
  - gapCnt: 4 bits.
- IDLE:
  - Waits for dispenseReq=1 with dispenseDone=0.
  - On that edge: remaining <= changeAmount, shortfall <= 0, go to SELECT.
- SELECT (one cycle):
  - If remaining==0, go to DONE.
  - Otherwise pick the largest denomination d in {100, 25, 10, 5} with d <= remaining and tube[d] > 0, then go to PULSE.
  - If no denomination qualifies (this covers remaining < 5 or empty tubes): shortfall <= remaining, go to DONE.
- PULSE (one cycle):
  - The chosen coin output is high for exactly this cycle.
  - tube[d] decrements and remaining <= remaining - d.
  - Next state is GAP if GAP>0, else SELECT.
- GAP: all coin outputs low for GAP cycles, then SELECT.
- Pulse spacing:
  - Successive eject pulses are GAP+2 cycles apart (4 with default GAP).
  - At most one coin output is high in any cycle.
- DONE:
  - dispenseDone=1.
  - Stays in DONE while dispenseReq=1.
  - When dispenseReq=0, go to IDLE with dispenseDone=0 on the same edge.
- Request dropped mid-dispense: ignored. Dispensing completes, then DONE lasts one cycle.
- Ordering: a new request is not accepted until dispenseDone has fallen (four-phase handshake).
- Refill:
  - Each *In pulse increments its tube, saturating at TUBE_MAX.
  - Refill and eject of the same tube in the same cycle gives a net change of 0.
  - Refill in any state takes effect for the next SELECT.
- changeLow is combinational from the nickel count: nickel count < LOW_THRESH.
- Width rules:
  - Subtraction never underflows, because d <= remaining is checked first.
  - Tube counters never go below 0 or above TUBE_MAX.

Test Plan:
- Default params, reset, changeAmount=140, request held → dollar, quarter, dime, nickel pulses in that order, 4 cycles apart; dispenseDone=1, shortfall=0; tubes 3/7/7/7; drop request → done low the next cycle.
- Dollar tube 1, changeAmount=200 → 1 dollar then 4 quarters (5 pulses total), shortfall=0, dollar tube 0.
- changeAmount=7 → one nickel, shortfall=2. changeAmount=0 → no pulses, dispenseDone two edges after acceptance.
- Nickel tube at 1 (changeLow=1) with nickelIn pulsed in the same cycle as the nickel eject → count stays 1. Then 300 nickelIn pulses from 0 → count saturates at 255.
- Assert rst asynchronously mid-GAP during a 140-cent dispense → outputs 0 immediately, tubes reload INIT values, no further pulses; a following request works normally.
- Drop dispenseReq after the first pulse → all coins still ejected, dispenseDone high exactly one cycle, then IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: turns a change value into coin-eject pulses using a greedy 100/25/10/5
// choice against per-denomination tube stock, with a four-phase request/done handshake.
module change_dispenser #(
  parameter int unsigned INIT_DOLLAR  = 4,
  parameter int unsigned INIT_QUARTER = 8,
  parameter int unsigned INIT_DIME    = 8,
  parameter int unsigned INIT_NICKEL  = 8,
  parameter int unsigned TUBE_MAX     = 255,
  parameter int unsigned GAP          = 2,
  parameter int unsigned LOW_THRESH   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dispenseReq,
  input  logic [8:0] changeAmount,
  input  logic       dollarIn,
  input  logic       quarterIn,
  input  logic       dimeIn,
  input  logic       nickelIn,
  output logic       dollarOut,
  output logic       quarterOut,
  output logic       dimeOut,
  output logic       nickelOut,
  output logic       dispenseDone,
  output logic       busy,
  output logic [8:0] shortfall,
  output logic       changeLow
);

  localparam logic [7:0] InitDollar  = 8'(INIT_DOLLAR);
  localparam logic [7:0] InitQuarter = 8'(INIT_QUARTER);
  localparam logic [7:0] InitDime    = 8'(INIT_DIME);
  localparam logic [7:0] InitNickel  = 8'(INIT_NICKEL);
  localparam logic [7:0] TubeMax     = 8'(TUBE_MAX);
  localparam logic [3:0] GapLen      = 4'(GAP);

  typedef enum logic [2:0] {StIdle, StSelect, StPulse, StGap, StDone} state_e;

  state_e     state_q, state_d;
  logic [8:0] remaining_q, remaining_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  // One-hot coin select {dollar, quarter, dime, nickel}; doubles as the eject outputs.
  logic [3:0] coin_q, coin_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [8:0] shortfall_q, shortfall_d;
  logic [7:0] dollar_cnt_q, dollar_cnt_d;
  logic [7:0] quarter_cnt_q, quarter_cnt_d;
  logic [7:0] dime_cnt_q, dime_cnt_d;
  logic [7:0] nickel_cnt_q, nickel_cnt_d;

  logic [3:0] pick;
  logic [8:0] coin_val;
  logic [3:0] eject;

  // Eject and refill in the same cycle cancel; refill saturates at TubeMax.
  function automatic logic [7:0] tube_next(input logic [7:0] cnt, input logic ej,
                                           input logic refill);
    logic [7:0] nxt;
    nxt = cnt;
    if (ej && !refill) begin
      nxt = cnt - 8'd1;
    end else if (refill && !ej && (cnt < TubeMax)) begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

  always_comb begin
    pick = 4'b0000;
    if ((remaining_q >= 9'd100) && (dollar_cnt_q != 8'd0)) begin
      pick = 4'b1000;
    end else if ((remaining_q >= 9'd25) && (quarter_cnt_q != 8'd0)) begin
      pick = 4'b0100;
    end else if ((remaining_q >= 9'd10) && (dime_cnt_q != 8'd0)) begin
      pick = 4'b0010;
    end else if ((remaining_q >= 9'd5) && (nickel_cnt_q != 8'd0)) begin
      pick = 4'b0001;
    end
  end

  always_comb begin
    coin_val = 9'd0;
    unique case (coin_q)
      4'b1000: coin_val = 9'd100;
      4'b0100: coin_val = 9'd25;
      4'b0010: coin_val = 9'd10;
      4'b0001: coin_val = 9'd5;
      default: coin_val = 9'd0;
    endcase
  end

  assign eject = (state_q == StPulse) ? coin_q : 4'b0000;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    shortfall_d = shortfall_q;
    coin_d      = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (dispenseReq && !done_q) begin
          remaining_d = changeAmount;
          shortfall_d = 9'd0;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        if (remaining_q == 9'd0) begin
          state_d = StDone;
        end else if (pick != 4'b0000) begin
          coin_d  = pick;
          state_d = StPulse;
        end else begin
          shortfall_d = remaining_q;
          state_d     = StDone;
        end
      end
      StPulse: begin
        remaining_d = remaining_q - coin_val;
        if (GapLen != 4'd0) begin
          gap_cnt_d = GapLen - 4'd1;
          state_d   = StGap;
        end else begin
          state_d = StSelect;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = StSelect;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (!dispenseReq) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    done_d = (state_d == StDone);
    busy_d = (state_d != StIdle);

    dollar_cnt_d  = tube_next(dollar_cnt_q, eject[3], dollarIn);
    quarter_cnt_d = tube_next(quarter_cnt_q, eject[2], quarterIn);
    dime_cnt_d    = tube_next(dime_cnt_q, eject[1], dimeIn);
    nickel_cnt_d  = tube_next(nickel_cnt_q, eject[0], nickelIn);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      remaining_q   <= 9'd0;
      gap_cnt_q     <= 4'd0;
      coin_q        <= 4'b0000;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      shortfall_q   <= 9'd0;
      dollar_cnt_q  <= InitDollar;
      quarter_cnt_q <= InitQuarter;
      dime_cnt_q    <= InitDime;
      nickel_cnt_q  <= InitNickel;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      gap_cnt_q     <= gap_cnt_d;
      coin_q        <= coin_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      shortfall_q   <= shortfall_d;
      dollar_cnt_q  <= dollar_cnt_d;
      quarter_cnt_q <= quarter_cnt_d;
      dime_cnt_q    <= dime_cnt_d;
      nickel_cnt_q  <= nickel_cnt_d;
    end
  end

  assign dollarOut    = coin_q[3];
  assign quarterOut   = coin_q[2];
  assign dimeOut      = coin_q[1];
  assign nickelOut    = coin_q[0];
  assign dispenseDone = done_q;
  assign busy         = busy_q;
  assign shortfall    = shortfall_q;
  assign changeLow    = (32'(nickel_cnt_q) < LOW_THRESH);

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized dispenses checked against
// a greedy coin model kept on plain integer tube counts.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int Gap = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       dispenseReq;
  logic [8:0] changeAmount;
  logic       dollarIn, quarterIn, dimeIn, nickelIn;
  logic       dollarOut, quarterOut, dimeOut, nickelOut;
  logic       dispenseDone, busy, changeLow;
  logic [8:0] shortfall;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk          (clk),
    .rst          (rst),
    .dispenseReq  (dispenseReq),
    .changeAmount (changeAmount),
    .dollarIn     (dollarIn),
    .quarterIn    (quarterIn),
    .dimeIn       (dimeIn),
    .nickelIn     (nickelIn),
    .dollarOut    (dollarOut),
    .quarterOut   (quarterOut),
    .dimeOut      (dimeOut),
    .nickelOut    (nickelOut),
    .dispenseDone (dispenseDone),
    .busy         (busy),
    .shortfall    (shortfall),
    .changeLow    (changeLow)
  );

  int errors = 0;
  int checks = 0;

  // Model: index 0 dollar, 1 quarter, 2 dime, 3 nickel.
  int denom[4]     = '{100, 25, 10, 5};
  int init_tube[4] = '{4, 8, 8, 8};
  int tube[4];
  int exp_seq[$];
  int exp_short;

  int   obs_seq[$];
  int   obs_cyc[$];
  bit   obs_multi, obs_busy_bad, obs_hold_ok, obs_refilled;
  int   obs_done_cyc, obs_shortfall;
  logic obs_done_after, obs_busy_after;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dut_tube(input int i);
    case (i)
      0:       return int'(dut.dollar_cnt_q);
      1:       return int'(dut.quarter_cnt_q);
      2:       return int'(dut.dime_cnt_q);
      default: return int'(dut.nickel_cnt_q);
    endcase
  endfunction

  task automatic model_dispense(input int amount);
    int rem;
    int pick;
    rem = amount;
    exp_seq.delete();
    exp_short = 0;
    while (rem > 0) begin
      pick = -1;
      for (int i = 0; i < 4; i++) begin
        if (pick < 0 && denom[i] <= rem && tube[i] > 0) pick = i;
      end
      if (pick < 0) begin
        exp_short = rem;
        break;
      end
      exp_seq.push_back(pick);
      tube[pick]--;
      rem -= denom[pick];
    end
  endtask

  function automatic bit seq_matches();
    if (obs_seq.size() != exp_seq.size()) return 1'b0;
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (obs_seq[i] != exp_seq[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit spacing_ok();
    for (int i = 1; i < obs_cyc.size(); i++) begin
      if (obs_cyc[i] - obs_cyc[i-1] != Gap + 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drives one request and records what the DUT did; comparisons live in the test tasks.
  task automatic do_dispense(input int amount, input bit drop, input bit refill_nk);
    int n;
    logic [3:0] outs;
    obs_seq.delete();
    obs_cyc.delete();
    obs_multi    = 1'b0;
    obs_busy_bad = 1'b0;
    obs_hold_ok  = 1'b1;
    obs_refilled = 1'b0;
    obs_done_cyc = -1;
    obs_shortfall = -1;
    changeAmount = 9'(amount);
    dispenseReq  = 1'b1;
    n = 0;
    while (n < 2000 && obs_done_cyc < 0) begin
      step();
      n++;
      nickelIn = 1'b0;
      outs = {dollarOut, quarterOut, dimeOut, nickelOut};
      if ($countones(outs) > 1) obs_multi = 1'b1;
      if (outs != 4'b0000) begin
        obs_seq.push_back(outs[3] ? 0 : outs[2] ? 1 : outs[1] ? 2 : 3);
        obs_cyc.push_back(n);
        if (drop) dispenseReq = 1'b0;
        if (refill_nk && outs[0]) begin
          nickelIn = 1'b1;
          obs_refilled = 1'b1;
        end
      end
      if (dispenseDone === 1'b1) begin
        obs_done_cyc  = n;
        obs_shortfall = int'(shortfall);
      end else if (busy !== 1'b1) begin
        obs_busy_bad = 1'b1;
      end
    end
    if (dispenseReq) begin
      repeat (2) begin
        step();
        if (dispenseDone !== 1'b1) obs_hold_ok = 1'b0;
      end
      dispenseReq = 1'b0;
    end
    step();
    nickelIn = 1'b0;
    obs_done_after = dispenseDone;
    obs_busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dispenseReq = 1'b0;
    changeAmount = 9'd0;
    {dollarIn, quarterIn, dimeIn, nickelIn} = 4'b0000;
    #3;
    for (int i = 0; i < 4; i++) tube[i] = init_tube[i];
    checks++;
    if ({dollarOut, quarterOut, dimeOut, nickelOut, dispenseDone, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {dollarOut, quarterOut, dimeOut, nickelOut, dispenseDone, busy});
    end
    checks++;
    if (shortfall !== 9'd0) begin
      errors++;
      $display("FAIL reset_shortfall: got %0d expected 0", shortfall);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_tube(i) !== tube[i]) begin
        errors++;
        $display("FAIL reset_tube%0d: got %0d expected %0d", i, dut_tube(i), tube[i]);
      end
    end
    checks++;
    if (changeLow !== 1'b0) begin
      errors++;
      $display("FAIL reset_changelow: got %b expected 0", changeLow);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    model_dispense(140);
    do_dispense(140, 1'b0, 1'b0);
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL basic_seq: got %0d coins expected %0d coins", obs_seq.size(), exp_seq.size());
    end
    checks++;
    if (!spacing_ok()) begin
      errors++;
      $display("FAIL basic_spacing: got irregular spacing expected %0d cycles", Gap + 2);
    end
    checks++;
    if (obs_multi || obs_busy_bad) begin
      errors++;
      $display("FAIL basic_onehot_busy: got multi=%0d busy_bad=%0d expected 0 0",
               obs_multi, obs_busy_bad);
    end
    checks++;
    if (obs_done_cyc < 0 || !obs_hold_ok) begin
      errors++;
      $display("FAIL basic_done: got cyc=%0d hold=%0d expected done held", obs_done_cyc,
               obs_hold_ok);
    end
    checks++;
    if (obs_shortfall !== exp_short) begin
      errors++;
      $display("FAIL basic_shortfall: got %0d expected %0d", obs_shortfall, exp_short);
    end
    checks++;
    if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got done=%b busy=%b expected 0 0", obs_done_after,
               obs_busy_after);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_tube(i) !== tube[i]) begin
        errors++;
        $display("FAIL basic_tube%0d: got %0d expected %0d", i, dut_tube(i), tube[i]);
      end
    end
  endtask

  task automatic test_dollar_short();
    model_dispense(200);
    do_dispense(200, 1'b0, 1'b0);
    model_dispense(200);
    do_dispense(200, 1'b0, 1'b0);
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL dollar_short_seq: got %0d coins expected %0d coins", obs_seq.size(),
               exp_seq.size());
    end
    checks++;
    if (obs_shortfall !== exp_short) begin
      errors++;
      $display("FAIL dollar_short_shortfall: got %0d expected %0d", obs_shortfall, exp_short);
    end
    checks++;
    if (dut_tube(0) !== tube[0]) begin
      errors++;
      $display("FAIL dollar_short_tube: got %0d expected %0d", dut_tube(0), tube[0]);
    end
  endtask

  task automatic test_shortfall_zero();
    model_dispense(7);
    do_dispense(7, 1'b0, 1'b0);
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL seven_seq: got %0d coins expected %0d coins", obs_seq.size(), exp_seq.size());
    end
    checks++;
    if (obs_shortfall !== exp_short) begin
      errors++;
      $display("FAIL seven_shortfall: got %0d expected %0d", obs_shortfall, exp_short);
    end
    model_dispense(0);
    do_dispense(0, 1'b0, 1'b0);
    checks++;
    if (obs_seq.size() != 0 || obs_done_cyc != 2) begin
      errors++;
      $display("FAIL zero_done: got coins=%0d done_cycle=%0d expected 0 coins cycle 2",
               obs_seq.size(), obs_done_cyc);
    end
    checks++;
    if (obs_shortfall !== 0) begin
      errors++;
      $display("FAIL zero_shortfall: got %0d expected 0", obs_shortfall);
    end
  endtask

  task automatic test_refill();
    while (tube[3] > 1) begin
      model_dispense(5);
      do_dispense(5, 1'b0, 1'b0);
    end
    checks++;
    if (changeLow !== (tube[3] < 2)) begin
      errors++;
      $display("FAIL refill_changelow_one: got %b expected %0d", changeLow, tube[3] < 2);
    end
    model_dispense(5);
    do_dispense(5, 1'b0, 1'b1);
    if (obs_refilled) tube[3] = (tube[3] + 1 > 255) ? 255 : tube[3] + 1;
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL refill_collide_seq: got %0d coins expected %0d", obs_seq.size(),
               exp_seq.size());
    end
    checks++;
    if (dut_tube(3) !== tube[3]) begin
      errors++;
      $display("FAIL refill_collide_count: got %0d expected %0d", dut_tube(3), tube[3]);
    end
    model_dispense(5);
    do_dispense(5, 1'b0, 1'b0);
    nickelIn = 1'b1;
    repeat (300) step();
    nickelIn = 1'b0;
    tube[3] = (tube[3] + 300 > 255) ? 255 : tube[3] + 300;
    step();
    checks++;
    if (dut_tube(3) !== tube[3]) begin
      errors++;
      $display("FAIL refill_saturate: got %0d expected %0d", dut_tube(3), tube[3]);
    end
    checks++;
    if (changeLow !== 1'b0) begin
      errors++;
      $display("FAIL refill_changelow_full: got %b expected 0", changeLow);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit seen, bad;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tube[i] = init_tube[i];
    changeAmount = 9'd140;
    dispenseReq  = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (dollarOut | quarterOut | dimeOut | nickelOut) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL areset_first_pulse: got none expected pulse within 20 cycles");
    end
    step();
    #2;
    rst = 1'b1;
    dispenseReq = 1'b0;
    #1;
    checks++;
    if ({dollarOut, quarterOut, dimeOut, nickelOut, dispenseDone, busy} !== 6'b0) begin
      errors++;
      $display("FAIL areset_outputs: got %b expected 000000",
               {dollarOut, quarterOut, dimeOut, nickelOut, dispenseDone, busy});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_tube(i) !== tube[i]) begin
        errors++;
        $display("FAIL areset_tube%0d: got %0d expected %0d", i, dut_tube(i), tube[i]);
      end
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      step();
      if (dollarOut | quarterOut | dimeOut | nickelOut | busy | dispenseDone) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL areset_quiet: got activity expected none after reset");
    end
    model_dispense(140);
    do_dispense(140, 1'b0, 1'b0);
    checks++;
    if (!seq_matches() || !spacing_ok()) begin
      errors++;
      $display("FAIL areset_after_seq: got %0d coins expected %0d", obs_seq.size(), exp_seq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_tube(i) !== tube[i]) begin
        errors++;
        $display("FAIL areset_after_tube%0d: got %0d expected %0d", i, dut_tube(i), tube[i]);
      end
    end
  endtask

  task automatic test_drop_req();
    model_dispense(140);
    do_dispense(140, 1'b1, 1'b0);
    checks++;
    if (!seq_matches()) begin
      errors++;
      $display("FAIL drop_seq: got %0d coins expected %0d", obs_seq.size(), exp_seq.size());
    end
    checks++;
    if (obs_done_cyc < 0 || obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL drop_done_once: got cyc=%0d done_after=%b busy_after=%b expected one-cycle",
               obs_done_cyc, obs_done_after, obs_busy_after);
    end
  endtask

  task automatic test_random();
    int k[4];
    int amount;
    bit drop;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 4; i++) k[i] = $urandom_range(0, 3);
      for (int c = 0; c < 3; c++) begin
        {dollarIn, quarterIn, dimeIn, nickelIn} = {c < k[0], c < k[1], c < k[2], c < k[3]};
        step();
      end
      {dollarIn, quarterIn, dimeIn, nickelIn} = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (k[i] > 3) k[i] = 3;
        tube[i] = (tube[i] + k[i] > 255) ? 255 : tube[i] + k[i];
      end
      amount = $urandom_range(0, 511);
      drop   = ($urandom_range(0, 3) == 0);
      model_dispense(amount);
      do_dispense(amount, drop, 1'b0);
      checks++;
      if (!seq_matches() || !spacing_ok() || obs_multi) begin
        errors++;
        $display("FAIL rand%0d_seq: amount=%0d got %0d coins expected %0d", it, amount,
                 obs_seq.size(), exp_seq.size());
      end
      checks++;
      if (obs_shortfall !== exp_short) begin
        errors++;
        $display("FAIL rand%0d_shortfall: got %0d expected %0d", it, obs_shortfall, exp_short);
      end
      checks++;
      if (obs_done_after !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_release: got %b expected 0", it, obs_done_after);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_tube(i) !== tube[i]) begin
          errors++;
          $display("FAIL rand%0d_tube%0d: got %0d expected %0d", it, i, dut_tube(i), tube[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dollar_short();
    test_shortfall_zero();
    test_refill();
    test_async_reset();
    test_drop_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
